// File: rtl/sobel_mag_pipe_if.sv
// Bundle of window, handshake, threshold and statistics signals between the
// window stage, the Sobel magnitude pipeline and its consumer.
interface sobel_mag_pipe_if #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
);
  logic [PIX_W-1:0] win00, win01, win02;
  logic [PIX_W-1:0] win10, win11, win12;
  logic [PIX_W-1:0] win20, win21, win22;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] thresh;
  logic             out_ready;
  logic             out_valid;
  logic [PIX_W-1:0] mag;
  // "edge" is a reserved word, so the flag carries a suffix.
  logic             edge_flag;
  logic             cnt_clr;
  logic [CNT_W-1:0] edge_cnt;

  modport master (
    output win00, win01, win02, win10, win11, win12, win20, win21, win22,
    output in_valid, thresh, out_ready, cnt_clr,
    input  in_ready, out_valid, mag, edge_flag, edge_cnt
  );

  modport slave (
    input  win00, win01, win02, win10, win11, win12, win20, win21, win22,
    input  in_valid, thresh, out_ready, cnt_clr,
    output in_ready, out_valid, mag, edge_flag, edge_cnt
  );
endinterface

// File: rtl/sobel_mag_pipe.sv
// Three-stage Sobel |Gx|+|Gy| magnitude with saturation, per-pixel threshold
// edge flag, global-stall backpressure and a saturating edge-pixel counter.
module sobel_mag_pipe #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sobel_mag_pipe_if.slave  bus
);
  localparam int SW = PIX_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [SW-1:0] psum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  logic             stall;
  logic [SW-1:0]    gx_p_d, gx_n_d, gy_p_d, gy_n_d;
  logic [SW-1:0]    gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic [PIX_W-1:0] thr1_q, thr2_q;
  logic             v1_q, v2_q;
  logic [SW-1:0]    abs_gx_d, abs_gy_d, abs_gx_q, abs_gy_q;
  logic [SW:0]      raw_d;
  logic [PIX_W-1:0] mag_d, mag_q;
  logic             edge_d, edge_q, out_valid_q;
  logic [CNT_W-1:0] cnt_q;

  // One global stall: every stage freezes while the output is blocked.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  assign gx_p_d = psum(bus.win02, bus.win12, bus.win22);
  assign gx_n_d = psum(bus.win00, bus.win10, bus.win20);
  assign gy_p_d = psum(bus.win20, bus.win21, bus.win22);
  assign gy_n_d = psum(bus.win00, bus.win01, bus.win02);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p_q <= '0;
      gx_n_q <= '0;
      gy_p_q <= '0;
      gy_n_q <= '0;
      thr1_q <= '0;
      v1_q   <= 1'b0;
    end else if (!stall) begin
      gx_p_q <= gx_p_d;
      gx_n_q <= gx_n_d;
      gy_p_q <= gy_p_d;
      gy_n_q <= gy_n_d;
      thr1_q <= bus.thresh;
      v1_q   <= bus.in_valid;
    end
  end

  assign abs_gx_d = (gx_p_q >= gx_n_q) ? (gx_p_q - gx_n_q) : (gx_n_q - gx_p_q);
  assign abs_gy_d = (gy_p_q >= gy_n_q) ? (gy_p_q - gy_n_q) : (gy_n_q - gy_p_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_gx_q <= '0;
      abs_gy_q <= '0;
      thr2_q   <= '0;
      v2_q     <= 1'b0;
    end else if (!stall) begin
      abs_gx_q <= abs_gx_d;
      abs_gy_q <= abs_gy_d;
      thr2_q   <= thr1_q;
      v2_q     <= v1_q;
    end
  end

  // Any bit above the pixel width means the sum exceeds full scale.
  assign raw_d  = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};
  assign mag_d  = (|raw_d[SW:PIX_W]) ? '1 : raw_d[PIX_W-1:0];
  assign edge_d = (mag_d > thr2_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mag_q       <= '0;
      edge_q      <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        mag_q  <= mag_d;
        edge_q <= edge_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (out_valid_q && bus.out_ready && edge_q && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.mag       = mag_q;
  assign bus.edge_flag = edge_q;
  assign bus.edge_cnt  = cnt_q;
endmodule

// File: tb/tb_sobel_mag_pipe.sv
// Bench for sobel_mag_pipe: directed vector table, stall pattern, random
// traffic against a scoreboard, mid-flight reset and counter saturation.
module tb_sobel_mag_pipe;
  localparam int CNT_MAX = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_mag_pipe_if #(.PIX_W(8), .CNT_W(16)) bus ();

  sobel_mag_pipe #(.PIX_W(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    bit [71:0] win;
    bit [7:0]  thr;
    bit [7:0]  mag;
    bit        edg;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Pixel k = r*3+c sits at bits [8k+7:8k].
  function automatic bit [71:0] mk(input bit [7:0] a00, a01, a02, a10, a11, a12,
                                   a20, a21, a22);
    return {a22, a21, a20, a12, a11, a10, a02, a01, a00};
  endfunction

  // Reference: Sobel straight from the definition with plain integers.
  function automatic bit [8:0] ref_px(input bit [71:0] w, input bit [7:0] thr);
    int p[9];
    int gx, gy, raw, m;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*8 +: 8]);
    gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy  = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    raw = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    m   = (raw > 255) ? 255 : raw;
    return {(m > int'(thr)), 8'(m)};
  endfunction

  function automatic bit [71:0] rnd_win();
    bit [71:0] w;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[71:64] = 8'($urandom);
    return w;
  endfunction

  task automatic set_win(input bit [71:0] w);
    bus.win00 = w[7:0];   bus.win01 = w[15:8];  bus.win02 = w[23:16];
    bus.win10 = w[31:24]; bus.win11 = w[39:32]; bus.win12 = w[47:40];
    bus.win20 = w[55:48]; bus.win21 = w[63:56]; bus.win22 = w[71:64];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard, stall-hold and counter model, sampled on the falling edge.
  logic [8:0] exp_q[$];
  int         model_cnt = 0;
  int         out_seen = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_mag = '0;
  logic       prev_edge = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    logic       hs;
    logic       e_edge;
    if (!rst_n) begin
      exp_q.delete();
      model_cnt  = 0;
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_mag", 32'(bus.mag), 32'(prev_mag));
        check("hold_edge", 32'(bus.edge_flag), 32'(prev_edge));
      end
      check("edge_cnt", 32'(bus.edge_cnt), 32'(model_cnt));
      hs = bus.out_valid && bus.out_ready;
      e_edge = 1'b0;
      if (hs) begin
        out_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          e_edge = e[8];
          check("sb_mag", 32'(bus.mag), 32'(e[7:0]));
          check("sb_edge", 32'(bus.edge_flag), 32'(e[8]));
        end
      end
      if (bus.cnt_clr) model_cnt = 0;
      else if (hs && e_edge && model_cnt < CNT_MAX) model_cnt++;
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_px({bus.win22, bus.win21, bus.win20, bus.win12, bus.win11,
                                bus.win10, bus.win02, bus.win01, bus.win00}, bus.thresh));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_mag   = bus.mag;
      prev_edge  = bus.edge_flag;
    end
  end

  // One pixel into an empty pipe: out_valid must rise on exactly the third clock.
  task automatic run_one(input string name, input bit [71:0] w, input bit [7:0] thr,
                         input bit [7:0] em, input bit ee);
    set_win(w);
    bus.thresh    = thr;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.in_valid = 1'b0;
      if (k < 3) begin
        check({name, "_early"}, 32'(bus.out_valid), 32'd0);
      end else begin
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_mag"}, 32'(bus.mag), 32'(em));
        check({name, "_edge"}, 32'(bus.edge_flag), 32'(ee));
      end
    end
    tick();
  endtask

  task automatic drain();
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 20) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(n >= 20), 32'd0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t      vecs[12];
    bit [71:0] ws[8];
    bit [11:0] pat;
    int        exp_cnt, idx, start, cyc;
    bit [71:0] cur;

    vecs[0]  = '{mk(100,100,100,100,100,100,100,100,100), 8'd0,   8'd0,   1'b0};
    vecs[1]  = '{mk(0,0,10, 0,0,10, 0,0,10),             8'd40,  8'd40,  1'b0};
    vecs[2]  = '{mk(0,0,10, 0,0,10, 0,0,10),             8'd39,  8'd40,  1'b1};
    vecs[3]  = '{mk(0,0,255, 0,0,255, 0,0,255),          8'd254, 8'd255, 1'b1};
    vecs[4]  = '{mk(0,0,255, 0,0,255, 0,0,255),          8'd255, 8'd255, 1'b0};
    vecs[5]  = '{mk(255,0,0, 255,0,0, 255,0,0),          8'd100, 8'd255, 1'b1};
    vecs[6]  = '{mk(10,10,10, 0,0,0, 0,0,0),             8'd0,   8'd40,  1'b1};
    vecs[7]  = '{mk(0,0,0, 0,200,0, 0,0,0),              8'd0,   8'd0,   1'b0};
    vecs[8]  = '{mk(50,0,0, 0,0,0, 0,0,0),               8'd99,  8'd100, 1'b1};
    vecs[9]  = '{mk(0,0,0, 0,0,0, 0,60,0),               8'd120, 8'd120, 1'b0};
    vecs[10] = '{mk(0,0,0, 0,0,0, 0,0,30),               8'd59,  8'd60,  1'b1};
    vecs[11] = '{mk(0,0,0, 0,0,100, 0,100,0),            8'd200, 8'd255, 1'b1};

    set_win('0);
    bus.thresh = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;

    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mag", 32'(bus.mag), 32'd0);
    check("rst_edge", 32'(bus.edge_flag), 32'd0);
    check("rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    #10 rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    exp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].win, vecs[i].thr, vecs[i].mag, vecs[i].edg);
      if (vecs[i].edg) exp_cnt++;
      check($sformatf("vec%0d_cnt", i), 32'(bus.edge_cnt), 32'(exp_cnt));
    end

    // Eight back-to-back windows against a fixed stall pattern.
    for (int i = 0; i < 8; i++) ws[i] = rnd_win();
    pat = 12'b101001101001;
    idx = 0; start = out_seen; cyc = 0;
    while ((idx < 8 || out_seen < start + 8) && cyc < 200) begin
      bus.out_ready = pat[cyc % 12];
      bus.in_valid  = (idx < 8);
      if (idx < 8) begin
        set_win(ws[idx]);
        bus.thresh = 8'(idx * 20);
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) idx++;
      tick();
      cyc++;
    end
    check("stall_seq_timeout", 32'(cyc >= 200), 32'd0);
    drain();
    check("stall_seq_count", 32'(out_seen - start), 32'd8);

    // Random traffic; a window is held until it is accepted.
    cur = rnd_win();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(3) != 0);
      bus.out_ready = ($urandom_range(2) != 0);
      set_win(cur);
      bus.thresh = 8'($urandom);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) cur = rnd_win();
      tick();
    end
    drain();

    // Reset with three pixels in flight.
    bus.out_ready = 1'b1;
    bus.thresh    = 8'd0;
    for (int i = 0; i < 3; i++) begin
      set_win(mk(0,0,8'(50 + i), 0,0,0, 0,0,0));
      bus.in_valid = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_cnt", 32'(bus.edge_cnt), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_stale_out", 32'(bus.out_valid), 32'd0);
    end
    run_one("post_rst", mk(0,0,10, 0,0,10, 0,0,10), 8'd39, 8'd40, 1'b1);

    // Counter saturation at 2^16-1, then clear colliding with an edge handshake.
    drain();
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    check("clr_cnt", 32'(bus.edge_cnt), 32'd0);
    set_win(mk(0,0,255, 0,0,255, 0,0,255));
    bus.thresh = 8'd0;
    bus.in_valid = 1'b1;
    repeat (65534) tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("cnt_65534", 32'(bus.edge_cnt), 32'd65534);
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("cnt_sat", 32'(bus.edge_cnt), 32'd65535);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("clr_hit_valid", 32'(bus.out_valid), 32'd1);
    check("clr_hit_edge", 32'(bus.edge_flag), 32'd1);
    bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0;
    check("clr_wins", 32'(bus.edge_cnt), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sobel_mag_pipe.md
Name: sobel_mag_pipe

Overview:
- Downstream consumer of the 3x3 window shift-register stage.
- Takes a 3x3 window of 8-bit pixels plus a valid strobe and computes Sobel Gx/Gy, |Gx|+|Gy| magnitude saturated to 8 bits, and a binary edge flag against a programmable threshold.
- 3-stage pipeline with valid/ready backpressure and a saturating edge-pixel counter for frame statistics.

Parameters:
- PIX_W, 8, pixel width; the only supported value is 8.
- CNT_W, 16, width of the edge-pixel counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- win00..win22  in  8 each  window pixels, row r/column c as winRC; row0 is top, col0 is left
- in_valid  in  1  window valid; driven by the window stage's start_conv
- in_ready  out  1  pipeline can accept this cycle
- thresh  in  8  edge threshold, sampled with each accepted window
- out_ready  in  1  downstream accepts output
- out_valid  out  1  output pixel valid
- mag  out  8  saturated magnitude
- edge  out  1  mag > thresh (strict)
- cnt_clr  in  1  synchronous clear of edge_cnt
- edge_cnt  out  CNT_W  count of accepted outputs with edge=1

Behaviour:
- Reset (async, rst_n=0): all stage valid bits=0, out_valid=0, mag=0, edge=0, edge_cnt=0. in_ready=1 immediately after reset release.
- Arithmetic:
  - Gx = (w02 + 2*w12 + w22) - (w00 + 2*w10 + w20).
  - Gy = (w20 + 2*w21 + w22) - (w00 + 2*w01 + w02).
  - Each partial sum is 10-bit unsigned (max 1020). Gx and Gy are 11-bit signed, range -1020..1020.
  - raw = |Gx| + |Gy|, 11-bit unsigned, max 2040.
  - mag = (raw > 255) ? 255 : raw[7:0].
  - edge = (mag > thresh_s3), where thresh_s3 is the threshold travelling with that pixel.
- Pipeline stages:
  - S1 registers the four partial sums, thresh, and v1.
  - S2 registers |Gx|, |Gy| (10-bit each), thresh, and v2.
  - S3 registers mag, edge, and out_valid.
- Latency: exactly 3 clk from an accepted input (in_valid & in_ready) to out_valid, when out_ready stays 1.
- Stall:
  - stall = out_valid & ~out_ready.
  - While stalled, all stage registers hold and in_ready=0.
  - in_ready = ~stall, combinational.
  - Input presented while in_ready=0 is not accepted; the upstream holds it.
- Bubbles: a stage with valid=0 still advances when not stalled. Data in an invalid stage is don't-care, but the output registers mag/edge hold their last value when out_valid=0.
- Throughput: 1 pixel/clk with no stalls. No pixel may be dropped or duplicated across any stall pattern.
- Output rule: out_valid, mag and edge must remain stable while out_valid=1 & out_ready=0.
- edge_cnt:
  - Increments by 1 on each output handshake (out_valid & out_ready) with edge=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 forces 0 on the next clk. If cnt_clr and an increment coincide, clear wins and the result is 0.
- thresh changes take effect per pixel, at acceptance time. Pixels already in flight use their captured threshold.
- Reset mid-operation: all in-flight pixels are discarded, out_valid drops to 0 asynchronously, and edge_cnt=0.

Test Plan:
- Uniform window, all 100, thresh=0, out_ready=1 -> 3 clk later out_valid=1, mag=0, edge=0, edge_cnt=0.
- Right column w02=w12=w22=10, others 0:
  - thresh=40 -> mag=40, edge=0.
  - Next pixel, same window with thresh=39 -> mag=40, edge=1, edge_cnt=1.
- Right column=255, others 0 (raw=1020) -> mag=255 (saturated), edge=1 with thresh=254; edge=0 with thresh=255.
- Stream of 8 windows back-to-back; out_ready toggles 1,0,0,1,0,1... -> all 8 outputs appear in order, unchanged while stalled; in_ready=0 exactly on stall cycles.
- Reach edge_cnt=65534, send 3 edge pixels -> edge_cnt holds at 65535. Assert cnt_clr in the same cycle as an edge handshake -> edge_cnt=0.
- Assert rst_n=0 with 3 pixels in flight -> out_valid=0 immediately; after release no stale outputs emerge and the first new pixel appears after 3 clk.
